output_arbiter: RTL

//  Per-output-port arbiter for the 5-port mesh router. Collects one request bit from

---
 rtl/output_arbiter_pkg.sv | 31 +++
 rtl/output_arbiter_if.sv | 37 +++
 rtl/output_arbiter_rr_priority_picker.sv | 35 +++
 rtl/output_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/output_arbiter_pkg.sv
// Shared router constants, port indices and arbiter FSM encoding.
// Also carries the round-robin pointer advance used by every output arbiter.
package output_arbiter_pkg;

    localparam int NUM_PORTS        = 5;
    localparam int PACKET_SIZE      = 32;
    localparam int FLIT_SIZE        = 4;
    localparam int FLITS_PER_PACKET = PACKET_SIZE / FLIT_SIZE;
    localparam int SEL_WIDTH        = 3;
    localparam int CNT_WIDTH        = $clog2(FLITS_PER_PACKET);

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef logic [NUM_PORTS-1:0] port_vec_t;
    typedef logic [SEL_WIDTH-1:0] port_sel_t;

    // Next search start after a packet from port sel: one past it, wrapping.
    function automatic port_sel_t next_ptr(input port_sel_t sel);
        return (sel == port_sel_t'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
    endfunction

endpackage

// File: rtl/output_arbiter_if.sv
// Request/grant bundle between the input ports and one output arbiter.
// master = requesting side (input ports / neighbour), slave = the arbiter.
interface output_arbiter_if;
    import output_arbiter_pkg::*;

    port_vec_t request;
    logic      downstream_full;
    port_vec_t grant;
    logic      grant_valid;
    port_sel_t xbar_select;
    port_vec_t stall_vector;
    logic      flit_valid;
    logic      packet_done;

    modport master (
        output request,
        output downstream_full,
        input  grant,
        input  grant_valid,
        input  xbar_select,
        input  stall_vector,
        input  flit_valid,
        input  packet_done
    );

    modport slave (
        input  request,
        input  downstream_full,
        output grant,
        output grant_valid,
        output xbar_select,
        output stall_vector,
        output flit_valid,
        output packet_done
    );

endinterface

// File: rtl/output_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
// Shared with the local injection allocator, so it stays free of any state.
module rr_priority_picker
    import output_arbiter_pkg::*;
#(
    parameter int N = NUM_PORTS,
    parameter int W = SEL_WIDTH
) (
    input  logic [N-1:0] request,
    input  logic [W-1:0] rr_ptr,
    output logic [N-1:0] winner,
    output logic [W-1:0] index,
    output logic         any
);

    int p;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        winner = '0;
        index  = '0;
        any    = 1'b0;
        p      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            p = (int'(rr_ptr) + i) % N;
            if (request[p]) begin
                winner = '0;
                winner[p] = 1'b1;
                index  = W'(p);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output wormhole arbiter: round-robin grant held for a whole packet,
// drives crossbar select, per-input stalls and the flit/packet strobes.
module output_arbiter
    import output_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output_arbiter_if.slave   bus
);

    arb_state_e                state;
    port_vec_t                 grant_q;
    port_sel_t                 sel_q;
    port_sel_t                 rr_ptr;
    logic [CNT_WIDTH-1:0]      flit_cnt;

    port_vec_t                 win_onehot;
    port_sel_t                 win_index;
    logic                      win_any;
    logic                      flit_valid;
    logic                      last_flit;

    rr_priority_picker #(
        .N (NUM_PORTS),
        .W (SEL_WIDTH)
    ) u_picker (
        .request (bus.request),
        .rr_ptr  (rr_ptr),
        .winner  (win_onehot),
        .index   (win_index),
        .any     (win_any)
    );

    // grant_q is one-hot, so masking avoids indexing request with a 3-bit select.
    assign flit_valid = (state == BUSY) & (|(bus.request & grant_q)) & ~bus.downstream_full;
    assign last_flit  = (flit_cnt == CNT_WIDTH'(FLITS_PER_PACKET - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            rr_ptr   <= '0;
            flit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        grant_q  <= win_onehot;
                        sel_q    <= win_index;
                        flit_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Bubbles (requester empty or downstream full) just hold everything.
                    if (flit_valid) begin
                        if (last_flit) begin
                            state    <= IDLE;
                            grant_q  <= '0;
                            sel_q    <= '0;
                            rr_ptr   <= next_ptr(sel_q);
                            flit_cnt <= '0;
                        end else begin
                            flit_cnt <= flit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.grant_valid  = |grant_q;
    assign bus.xbar_select  = sel_q;
    assign bus.stall_vector = ~grant_q | {NUM_PORTS{bus.downstream_full}};
    assign bus.flit_valid   = flit_valid;
    assign bus.packet_done  = flit_valid & last_flit;

endmodule
